// File: rtl/pcie_frame_unpack.sv
// Unpacks 128-bit CPU frame words (six RGB565 pixels + frame index) into one pixel per de_in, with sync and error recovery.
// Latency: outputs one cycle after de_in; FIFO data consumed one cycle after fifo_rd_en; at most one read outstanding.
module pcie_frame_unpack #(
  parameter int unsigned FRAME_PIX = 921600,
  parameter bit          SWAP_EN   = 1'b1,
  parameter logic [15:0] FILL_PIX  = 16'h0000
) (
  input  logic         hdmi_clk,
  input  logic         rst_n,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  input  logic [127:0] fifo_rd_data,
  input  logic         vs_in,
  input  logic         de_in,
  output logic [15:0]  pix_out,
  output logic         pix_vld,
  output logic         underrun,
  output logic         seq_err,
  output logic         frame_done,
  output logic [15:0]  frame_cnt
);
  typedef enum logic [1:0] {WAIT_VS, SYNC, RUN, DRAIN} state_e;
  localparam logic [19:0] LAST_IDX = 20'(FRAME_PIX - 6);

  state_e          state_q, state_d;
  logic [127:0]    act_q, act_d, pre_q, pre_d, word, cand;
  logic            act_vld_q, act_vld_d, pre_vld_q, pre_vld_d, cand_vld;
  logic [2:0]      slot_q, slot_d;
  logic [19:0]     exp_q, exp_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            vs_q, rd_pend_q, vs_rise, pre_take;
  logic            serve, urun, serr, fdone;
  logic [15:0]     pix_q;
  logic            vld_q, urun_q, serr_q, fdone_q;
  logic [7:0][15:0] act_pix;
  logic [20:0]     fetch_idx;

  // CPU stores each 32-bit lane little-endian; restore big-endian field order.
  always_comb begin
    word = fifo_rd_data;
    if (SWAP_EN) begin
      for (int l = 0; l < 4; l++) begin
        for (int b = 0; b < 4; b++) begin
          word[32*l+8*b +: 8] = fifo_rd_data[32*l+8*(3-b) +: 8];
        end
      end
    end
  end

  assign act_pix  = act_q;
  assign vs_rise  = vs_in & ~vs_q;
  assign pre_take = (state_q == RUN) && de_in && act_vld_q && (slot_q == 3'd5) && pre_vld_q;
  // Index of the next word to be fetched; the frame's last word stops further reads.
  assign fetch_idx  = {1'b0, exp_q} + (pre_vld_q ? 21'd6 : 21'd0);
  assign fifo_rd_en = !fifo_empty && !rd_pend_q && (!pre_vld_q || pre_take) &&
                      ((state_q == SYNC) || ((state_q == RUN) && (fetch_idx <= {1'b0, LAST_IDX})));

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    act_vld_d = act_vld_q;
    slot_d    = slot_q;
    pre_d     = pre_q;
    pre_vld_d = pre_vld_q;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    cand      = '0;
    cand_vld  = 1'b0;
    serve     = 1'b0;
    urun      = 1'b0;
    serr      = 1'b0;
    fdone     = 1'b0;
    case (state_q)
      WAIT_VS, DRAIN: begin
        if (vs_rise) begin
          state_d = SYNC;
          exp_d   = '0;
        end
      end
      SYNC: begin
        if (vs_rise) exp_d = '0;
        if (de_in) begin
          urun    = 1'b1;
          state_d = DRAIN;
        end else if (rd_pend_q && (word[19:0] == 20'd0)) begin
          act_d     = word;
          act_vld_d = 1'b1;
          slot_d    = 3'd0;
          exp_d     = 20'd6;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (de_in && act_vld_q && (slot_q == 3'd5) && (act_q[19:0] == LAST_IDX)) begin
          serve     = 1'b1;
          fdone     = 1'b1;
          cnt_d     = cnt_q + 16'd1;
          act_vld_d = 1'b0;
          pre_vld_d = 1'b0;
          exp_d     = '0;
          state_d   = vs_rise ? SYNC : WAIT_VS;
        end else if (vs_rise) begin
          serr      = 1'b1;
          act_vld_d = 1'b0;
          pre_vld_d = 1'b0;
          exp_d     = '0;
          state_d   = SYNC;
        end else begin
          if (de_in && act_vld_q) begin
            serve = 1'b1;
            if (slot_q == 3'd5) act_vld_d = 1'b0;
            else                slot_d    = slot_q + 3'd1;
          end
          // The index is checked when a word becomes active, not when it is prefetched.
          if (!act_vld_d && pre_vld_q) begin
            cand      = pre_q;
            cand_vld  = 1'b1;
            pre_vld_d = 1'b0;
          end else if (!act_vld_d && rd_pend_q) begin
            cand     = word;
            cand_vld = 1'b1;
          end else if (rd_pend_q) begin
            pre_d     = word;
            pre_vld_d = 1'b1;
          end
          if (cand_vld && (cand[19:0] != exp_q)) begin
            serr = 1'b1;
          end else if (cand_vld) begin
            act_d     = cand;
            act_vld_d = 1'b1;
            slot_d    = 3'd0;
            exp_d     = exp_q + 20'd6;
          end
          if (de_in && !act_vld_q && !serr) urun = 1'b1;
          if (serr || urun) begin
            act_vld_d = 1'b0;
            pre_vld_d = 1'b0;
            state_d   = DRAIN;
          end
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge hdmi_clk) begin
    if (!rst_n) begin
      state_q   <= WAIT_VS;
      act_q     <= '0;
      act_vld_q <= 1'b0;
      pre_q     <= '0;
      pre_vld_q <= 1'b0;
      slot_q    <= '0;
      exp_q     <= '0;
      cnt_q     <= '0;
      vs_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      pix_q     <= '0;
      vld_q     <= 1'b0;
      urun_q    <= 1'b0;
      serr_q    <= 1'b0;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      act_vld_q <= act_vld_d;
      pre_q     <= pre_d;
      pre_vld_q <= pre_vld_d;
      slot_q    <= slot_d;
      exp_q     <= exp_d;
      cnt_q     <= cnt_d;
      vs_q      <= vs_in;
      rd_pend_q <= fifo_rd_en;
      pix_q     <= serve ? act_pix[3'd7 - slot_q] : FILL_PIX;
      vld_q     <= de_in;
      urun_q    <= urun;
      serr_q    <= serr;
      fdone_q   <= fdone;
    end
  end

  assign pix_out    = pix_q;
  assign pix_vld    = vld_q;
  assign underrun   = urun_q;
  assign seq_err    = serr_q;
  assign frame_done = fdone_q;
  assign frame_cnt  = cnt_q;

endmodule
